// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one WxW multiplier tree between two requesters,
// fixed two-cycle latency. Optional requester-1 lock mode is enabled by `MULARB_LOCK_EN.
module mul_share_arbiter #(
   parameter int W = 58
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req0_valid,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   output logic           req0_ready,
   input  logic           req1_valid,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   output logic           req1_ready,
`ifdef MULARB_LOCK_EN
   input  logic           req1_lock,
`endif
   output logic [W-1:0]   mul_a,
   output logic [W-1:0]   mul_b,
   input  logic [2*W-1:0] mul_p,
   output logic           resp0_valid,
   output logic           resp1_valid,
   output logic [2*W-1:0] resp_prod,
   output logic           busy
);

   logic rr;
   logic locked;
   logic lock_exit;
   logic accept;
   logic v1, v2;
   logic tag1, tag2;

`ifdef MULARB_LOCK_EN
   // state | meaning
   // ARB   | round-robin between both requesters
   // LOCK1 | requester 1 owns the multiplier, requester 0 stalled
   localparam logic [0:0] ST_ARB   = 1'b0;
   localparam logic [0:0] ST_LOCK1 = 1'b1;

   logic [0:0] state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_ARB;
      end else begin
         case (state)
            ST_ARB:  if (req1_ready && req1_lock) state <= ST_LOCK1;
            default: if (!req1_lock) state <= ST_ARB;
         endcase
      end
   end

   assign locked    = (state == ST_LOCK1);
   // a req1 accept with lock low and lock dropping while idle both reduce to lock low
   assign lock_exit = locked && !req1_lock;
`else
   assign locked    = 1'b0;
   assign lock_exit = 1'b0;
`endif

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (locked) begin
         req1_ready = req1_valid;
      end else if (req0_valid && req1_valid) begin
         req0_ready = ~rr;
         req1_ready = rr;
      end else begin
         req0_ready = req0_valid;
         req1_ready = req1_valid;
      end
   end

   assign accept = req0_ready | req1_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         rr        <= 1'b0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         tag1      <= 1'b0;
         tag2      <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         resp_prod <= '0;
      end else begin
         v1   <= accept;
         v2   <= v1;
         tag2 <= tag1;
         // operands only load on accept so the tree inputs stay quiet when idle
         if (accept) begin
            tag1  <= req1_ready;
            mul_a <= req1_ready ? req1_a : req0_a;
            mul_b <= req1_ready ? req1_b : req0_b;
            rr    <= req0_ready;
         end
         if (lock_exit) rr <= 1'b0;
         if (v1) resp_prod <= mul_p;
      end
   end

   assign resp0_valid = v2 & ~tag2;
   assign resp1_valid = v2 & tag2;
   assign busy        = v1 | v2;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: vector table, hand sequences and random traffic
// against a queue-based model of grants and latency-2 responses.
module tb_mul_share_arbiter;
   localparam int W = 58;

   logic           clk = 1'b0;
   logic           reset;
   logic           req0_valid, req1_valid;
   logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
   logic           req0_ready, req1_ready;
   logic [W-1:0]   mul_a, mul_b;
   logic [2*W-1:0] mul_p;
   logic           resp0_valid, resp1_valid;
   logic [2*W-1:0] resp_prod;
   logic           busy;
`ifdef MULARB_LOCK_EN
   logic           req1_lock;
`endif

   always #5 clk = ~clk;

   // combinational multiplier tree seen by the DUT
   assign mul_p = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};

   mul_share_arbiter #(.W(W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
`ifdef MULARB_LOCK_EN
      .req1_lock(req1_lock),
`endif
      .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
      .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_prod(resp_prod),
      .busy(busy)
   );

   typedef struct {
      logic         v0;
      logic [W-1:0] a0, b0;
      logic         v1;
      logic [W-1:0] a1, b1;
      logic         rst;
      logic         e0, e1;
   } vec_t;

   typedef struct {
      int             due;
      bit             port;
      logic [2*W-1:0] p;
   } rsp_t;

   rsp_t         q[$];
   int           cyc;
   bit           m_ptr, m_locked, lk;
   logic [W-1:0] m_a, m_b;
   int           n_chk, n_err;
   logic         s_r0, s_r1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input logic rst);
      bit e0, e1;
      logic [2*W-1:0] pr;
      req0_valid = v0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_a = a1; req1_b = b1;
      reset = rst;
`ifdef MULARB_LOCK_EN
      req1_lock = lk;
`endif
      if (m_locked) begin
         e0 = 1'b0; e1 = v1;
      end else if (v0 && v1) begin
         e0 = (m_ptr == 1'b0); e1 = (m_ptr == 1'b1);
      end else begin
         e0 = v0; e1 = v1;
      end
      #1;
      s_r0 = req0_ready; s_r1 = req1_ready;
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      @(posedge clk);
      if (rst) begin
         q.delete(); m_ptr = 1'b0; m_locked = 1'b0; m_a = '0; m_b = '0;
      end else begin
         if (e0 || e1) begin
            m_ptr = e0;
            m_a = e1 ? a1 : a0;
            m_b = e1 ? b1 : b0;
            pr = {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};
            q.push_back('{cyc + 2, e1, pr});
         end
         if (!m_locked) begin
            if (e1 && lk) m_locked = 1'b1;
         end else if (!lk) begin
            m_locked = 1'b0; m_ptr = 1'b0;
         end
      end
      cyc++;
      @(negedge clk);
      chk("busy", busy, q.size() > 0);
      if (q.size() > 0 && q[0].due == cyc) begin
         chk("resp0_valid", resp0_valid, !q[0].port);
         chk("resp1_valid", resp1_valid, q[0].port);
         chk("resp_prod", resp_prod, q[0].p);
         void'(q.pop_front());
      end else begin
         chk("resp0_valid", resp0_valid, 1'b0);
         chk("resp1_valid", resp1_valid, 1'b0);
      end
      chk("mul_a", mul_a, m_a);
      chk("mul_b", mul_b, m_b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
   endtask

   initial begin
      vec_t           vt[$];
      logic [W-1:0]   mx;
      logic [2*W-1:0] maxp;
      logic [63:0]    r;
      logic           rv0, rv1, rrst;
      logic [W-1:0]   ra0, rb0, ra1, rb1;

      n_chk = 0; n_err = 0; cyc = 0;
      m_ptr = 1'b0; m_locked = 1'b0; lk = 1'b0; m_a = '0; m_b = '0;
      mx = '1;
      maxp = {(2*W){1'b1}} - ((2*W)'(1) << (W + 1)) + (2*W)'(2);

      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
      chk("rst_resp_prod", resp_prod, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_mul_a", mul_a, '0);

      vt.push_back('{1'b1, 58'd3, 58'd5, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0});
      vt.push_back('{1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0});
      vt.push_back('{1'b1, 58'd11, 58'd2, 1'b1, 58'd13, 58'd3, 1'b0, 1'b1, 1'b0});
      vt.push_back('{1'b1, 58'd17, 58'd4, 1'b1, 58'd19, 58'd5, 1'b0, 1'b0, 1'b1});
      vt.push_back('{1'b1, 58'd23, 58'd6, 1'b1, 58'd29, 58'd7, 1'b0, 1'b1, 1'b0});
      vt.push_back('{1'b1, 58'd31, 58'd8, 1'b1, 58'd37, 58'd9, 1'b0, 1'b0, 1'b1});
      vt.push_back('{1'b0, '0, '0, 1'b1, mx, mx, 1'b0, 1'b0, 1'b1});
      vt.push_back('{1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0});
      for (int k = 0; k < 4; k++)
         vt.push_back('{1'b0, '0, '0, 1'b1, W'(100 + k), W'(200 + k), 1'b0, 1'b0, 1'b1});
      vt.push_back('{1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 58'd41, 58'd43, 1'b1, 58'd47, 58'd53, 1'b0, 1'b1, 1'b0});
      vt.push_back('{1'b1, 58'd59, 58'd61, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0});
      vt.push_back('{1'b1, 58'd67, 58'd71, 1'b1, 58'd73, 58'd79, 1'b0, 1'b0, 1'b1});
      vt.push_back('{1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0});

      foreach (vt[i]) begin
         step(vt[i].v0, vt[i].a0, vt[i].b0, vt[i].v1, vt[i].a1, vt[i].b1, vt[i].rst);
         chk("tbl_ready0", s_r0, vt[i].e0);
         chk("tbl_ready1", s_r1, vt[i].e1);
      end

      // request 3*5 from port 0: response two cycles later
      step(1'b1, 58'd3, 58'd5, 1'b0, '0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      chk("t1_resp0", resp0_valid, 1'b1);
      chk("t1_prod", resp_prod, 116'd15);
      idle(1);

      // full-scale operands on port 1
      step(1'b0, '0, '0, 1'b1, mx, mx, 1'b0);
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      chk("max_resp1", resp1_valid, 1'b1);
      chk("max_resp0", resp0_valid, 1'b0);
      chk("max_prod", resp_prod, maxp);
      idle(1);

      // reset one cycle after an accept drops the operation
      step(1'b1, 58'd7, 58'd9, 1'b0, '0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
      chk("rstmid_resp0", resp0_valid, 1'b0);
      chk("rstmid_busy", busy, 1'b0);
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      chk("rstmid_busy2", busy, 1'b0);
      chk("rstmid_resp0b", resp0_valid, 1'b0);

`ifdef MULARB_LOCK_EN
      lk = 1'b1;
      step(1'b0, '0, '0, 1'b1, 58'd5, 58'd6, 1'b0);
      step(1'b1, 58'd2, 58'd3, 1'b1, 58'd7, 58'd8, 1'b0);
      chk("lock_r0", s_r0, 1'b0);
      chk("lock_r1", s_r1, 1'b1);
      lk = 1'b0;
      step(1'b1, 58'd2, 58'd3, 1'b1, 58'd9, 58'd10, 1'b0);
      chk("unlock_r0", s_r0, 1'b0);
      step(1'b1, 58'd2, 58'd3, 1'b1, 58'd11, 58'd12, 1'b0);
      chk("after_lock_r0", s_r0, 1'b1);
      idle(2);
`endif

      for (int i = 0; i < 400; i++) begin
         rv0  = 1'($urandom_range(0, 1));
         rv1  = 1'($urandom_range(0, 1));
         rrst = ($urandom_range(0, 39) == 0);
         r = {$urandom, $urandom}; ra0 = r[W-1:0];
         r = {$urandom, $urandom}; rb0 = r[W-1:0];
         r = {$urandom, $urandom}; ra1 = r[W-1:0];
         r = {$urandom, $urandom}; rb1 = r[W-1:0];
`ifdef MULARB_LOCK_EN
         lk = ($urandom_range(0, 3) == 0);
`endif
         step(rv0, ra0, rb0, rv1, ra1, rb1, rrst);
      end
      lk = 1'b0;
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule
